// File: rtl/mant_addsub_ctrl.sv
// Signed-magnitude mantissa add/subtract controller for the FP adder datapath.
// Optional feature macro: MANT_NORM_EN (adds the NORM state for left-normalization).

// N-bit ripple adder with carry in/out
module Nbit_FullAdder #(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  logic         i_ci,
  output logic [N-1:0] o_s,
  output logic         o_co
);
  assign {o_co, o_s} = (N+1)'(i_a) + (N+1)'(i_b) + (N+1)'(i_ci);
endmodule

// Two's-complement fix-up of a subtract result that borrowed (no carry out)
module postcomplement #(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0] i_operand,
  input  logic         i_co,
  input  logic         i_eff_sub,
  output logic [N-1:0] o_result
);
  logic w_complement;
  assign w_complement = i_eff_sub & ~i_co;
  assign o_result     = w_complement ? (~i_operand + N'(1)) : i_operand;
endmodule

module mant_addsub_ctrl #(
  parameter int unsigned N = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_i,
  output logic                   ready_o,
  input  logic                   sign_a_i,
  input  logic [N-1:0]           mag_a_i,
  input  logic                   sign_b_i,
  input  logic [N-1:0]           mag_b_i,
  input  logic                   op_sub_i,
  output logic                   done_o,
  output logic                   sign_o,
  output logic [N-1:0]           mag_o,
  output logic                   carry_o,
  output logic                   zero_o,
  output logic [$clog2(N)-1:0]   shift_o
);
  localparam int unsigned SW = $clog2(N);

  typedef enum logic [2:0] {S_IDLE, S_ADD, S_FIX, S_NORM, S_DONE} state_t;

  state_t         r_state, w_next;
  logic           r_sign_a, r_sign_bx, r_eff_sub;
  logic [N-1:0]   r_mag_a, r_mag_b;
  logic [N-1:0]   r_s;
  logic           r_co;
  logic [N-1:0]   r_mag;
  logic           r_sign, r_carry, r_zero;
  logic           r_done, r_ready, r_sign_o, r_carry_o, r_zero_o;
  logic [N-1:0]   r_mag_o;

  logic [N-1:0]   w_add_b, w_s, w_op_comp;
  logic           w_co, w_carry, w_zero, w_sign;

  assign w_add_b = r_eff_sub ? ~r_mag_b : r_mag_b;

  Nbit_FullAdder #(.N(N)) u_adder (
    .i_a (r_mag_a),
    .i_b (w_add_b),
    .i_ci(r_eff_sub),
    .o_s (w_s),
    .o_co(w_co)
  );

  postcomplement #(.N(N)) u_postcomp (
    .i_operand(r_s),
    .i_co     (r_co),
    .i_eff_sub(r_eff_sub),
    .o_result (w_op_comp)
  );

  assign w_carry = ~r_eff_sub & r_co;
  assign w_zero  = (w_op_comp == '0);
  assign w_sign  = (r_eff_sub & ~r_co) ? r_sign_bx : r_sign_a;

`ifdef MANT_NORM_EN
  logic [SW-1:0]  r_shift, r_shift_o;
  logic           w_norm_req;
  assign w_norm_req = ~w_zero & ~w_carry & ~w_op_comp[N-1];
  assign shift_o    = r_shift_o;
`else
  assign shift_o    = '0;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (start_i) w_next = S_ADD;
      S_ADD:  w_next = S_FIX;
`ifdef MANT_NORM_EN
      S_FIX:  w_next = w_norm_req ? S_NORM : S_DONE;
      // exit once the bit shifting into the MSB is a one
      S_NORM: if (r_mag[N-2]) w_next = S_DONE;
`else
      S_FIX:  w_next = S_DONE;
`endif
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Operand latch and working datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sign_a  <= 1'b0;
      r_sign_bx <= 1'b0;
      r_eff_sub <= 1'b0;
      r_mag_a   <= '0;
      r_mag_b   <= '0;
      r_s       <= '0;
      r_co      <= 1'b0;
      r_mag     <= '0;
      r_sign    <= 1'b0;
      r_carry   <= 1'b0;
      r_zero    <= 1'b0;
`ifdef MANT_NORM_EN
      r_shift   <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: if (start_i) begin
          r_sign_a  <= sign_a_i;
          r_sign_bx <= sign_b_i ^ op_sub_i;
          r_eff_sub <= sign_a_i ^ sign_b_i ^ op_sub_i;
          r_mag_a   <= mag_a_i;
          r_mag_b   <= mag_b_i;
        end
        S_ADD: begin
          r_s  <= w_s;
          r_co <= w_co;
        end
        S_FIX: begin
          r_mag   <= w_op_comp;
          r_carry <= w_carry;
          r_zero  <= w_zero;
          r_sign  <= w_zero ? 1'b0 : w_sign;
`ifdef MANT_NORM_EN
          r_shift <= '0;
`endif
        end
`ifdef MANT_NORM_EN
        S_NORM: begin
          r_mag   <= {r_mag[N-2:0], 1'b0};
          r_shift <= r_shift + SW'(1);
        end
`endif
        default: ;
      endcase
    end
  end

  // Handshake and result output registers; results held until next completion
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ready   <= 1'b1;
      r_done    <= 1'b0;
      r_sign_o  <= 1'b0;
      r_mag_o   <= '0;
      r_carry_o <= 1'b0;
      r_zero_o  <= 1'b0;
`ifdef MANT_NORM_EN
      r_shift_o <= '0;
`endif
    end else begin
      r_ready <= (w_next == S_IDLE);
      r_done  <= (r_state == S_DONE);
      if (r_state == S_DONE) begin
        r_sign_o  <= r_sign;
        r_mag_o   <= r_mag;
        r_carry_o <= r_carry;
        r_zero_o  <= r_zero;
`ifdef MANT_NORM_EN
        r_shift_o <= r_shift;
`endif
      end
    end
  end

  assign ready_o = r_ready;
  assign done_o  = r_done;
  assign sign_o  = r_sign_o;
  assign mag_o   = r_mag_o;
  assign carry_o = r_carry_o;
  assign zero_o  = r_zero_o;

endmodule

// File: tb/tb_mant_addsub_ctrl.sv
// Directed-vector bench for mant_addsub_ctrl (N=8); expectations follow MANT_NORM_EN.
module tb_mant_addsub_ctrl;
  localparam int unsigned N  = 8;
  localparam int unsigned SW = 3;
`ifdef MANT_NORM_EN
  localparam bit NORM = 1'b1;
`else
  localparam bit NORM = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start_i = 1'b0;
  logic          ready_o;
  logic          sign_a_i = 1'b0;
  logic [N-1:0]  mag_a_i = '0;
  logic          sign_b_i = 1'b0;
  logic [N-1:0]  mag_b_i = '0;
  logic          op_sub_i = 1'b0;
  logic          done_o, sign_o, carry_o, zero_o;
  logic [N-1:0]  mag_o;
  logic [SW-1:0] shift_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mant_addsub_ctrl #(.N(N)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .ready_o(ready_o),
    .sign_a_i(sign_a_i), .mag_a_i(mag_a_i), .sign_b_i(sign_b_i), .mag_b_i(mag_b_i),
    .op_sub_i(op_sub_i), .done_o(done_o), .sign_o(sign_o), .mag_o(mag_o),
    .carry_o(carry_o), .zero_o(zero_o), .shift_o(shift_o)
  );

  // Issue one operation, scramble the inputs after acceptance, count edges to done_o
  task automatic do_op(input logic sa, input logic [N-1:0] ma, input logic sb,
                       input logic [N-1:0] mb, input logic sub, output int edges);
    @(negedge clk);
    sign_a_i = sa; mag_a_i = ma; sign_b_i = sb; mag_b_i = mb; op_sub_i = sub;
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    sign_a_i = ~sa; mag_a_i = ~ma; sign_b_i = ~sb; mag_b_i = ~mb; op_sub_i = ~sub;
    edges = 0;
    while (done_o !== 1'b1 && edges < 40) begin
      @(posedge clk); #1;
      edges++;
    end
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    #10;
    n_checks += 7;
    if (ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", ready_o); end
    if (done_o  !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done_o); end
    if (mag_o   !== 8'd0) begin n_fail++; $display("FAIL reset_mag got %0d want 0", mag_o); end
    if (sign_o  !== 1'b0) begin n_fail++; $display("FAIL reset_sign got %b want 0", sign_o); end
    if (carry_o !== 1'b0) begin n_fail++; $display("FAIL reset_carry got %b want 0", carry_o); end
    if (zero_o  !== 1'b0) begin n_fail++; $display("FAIL reset_zero got %b want 0", zero_o); end
    if (shift_o !== 3'd0) begin n_fail++; $display("FAIL reset_shift got %0d want 0", shift_o); end
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic test_add_overflow();
    int e;
    do_op(1'b0, 8'd200, 1'b0, 8'd100, 1'b0, e);
    n_checks += 6;
    if (e != 3)           begin n_fail++; $display("FAIL ovf_latency got %0d want 3", e); end
    if (mag_o   !== 8'd44) begin n_fail++; $display("FAIL ovf_mag got %0d want 44", mag_o); end
    if (carry_o !== 1'b1) begin n_fail++; $display("FAIL ovf_carry got %b want 1", carry_o); end
    if (sign_o  !== 1'b0) begin n_fail++; $display("FAIL ovf_sign got %b want 0", sign_o); end
    if (zero_o  !== 1'b0) begin n_fail++; $display("FAIL ovf_zero got %b want 0", zero_o); end
    if (shift_o !== 3'd0) begin n_fail++; $display("FAIL ovf_shift got %0d want 0", shift_o); end
    @(posedge clk); #1;
    n_checks += 2;
    if (done_o !== 1'b0)  begin n_fail++; $display("FAIL done_pulse got %b want 0", done_o); end
    if (mag_o  !== 8'd44) begin n_fail++; $display("FAIL mag_hold got %0d want 44", mag_o); end
  endtask

  task automatic test_subtract();
    int e;
    logic [N-1:0] m70;
    logic [SW-1:0] s70;
    m70 = NORM ? 8'd140 : 8'd70;
    s70 = NORM ? 3'd1 : 3'd0;
    // +100 - +30
    do_op(1'b0, 8'd100, 1'b0, 8'd30, 1'b1, e);
    n_checks += 5;
    if (e != (NORM ? 4 : 3)) begin n_fail++; $display("FAIL sub_latency got %0d want %0d", e, NORM ? 4 : 3); end
    if (mag_o   !== m70)  begin n_fail++; $display("FAIL sub_mag got %0d want %0d", mag_o, m70); end
    if (sign_o  !== 1'b0) begin n_fail++; $display("FAIL sub_sign got %b want 0", sign_o); end
    if (carry_o !== 1'b0) begin n_fail++; $display("FAIL sub_carry got %b want 0", carry_o); end
    if (shift_o !== s70)  begin n_fail++; $display("FAIL sub_shift got %0d want %0d", shift_o, s70); end
    // +30 - +100 : complement path, negative result
    do_op(1'b0, 8'd30, 1'b0, 8'd100, 1'b1, e);
    n_checks += 3;
    if (mag_o   !== m70)  begin n_fail++; $display("FAIL comp_mag got %0d want %0d", mag_o, m70); end
    if (sign_o  !== 1'b1) begin n_fail++; $display("FAIL comp_sign got %b want 1", sign_o); end
    if (carry_o !== 1'b0) begin n_fail++; $display("FAIL comp_carry got %b want 0", carry_o); end
    // -30 + +100
    do_op(1'b1, 8'd30, 1'b0, 8'd100, 1'b0, e);
    n_checks += 2;
    if (mag_o  !== m70)  begin n_fail++; $display("FAIL negadd_mag got %0d want %0d", mag_o, m70); end
    if (sign_o !== 1'b0) begin n_fail++; $display("FAIL negadd_sign got %b want 0", sign_o); end
    // +200 - 0 : magnitude passes through unchanged
    do_op(1'b0, 8'd200, 1'b0, 8'd0, 1'b1, e);
    n_checks += 2;
    if (mag_o   !== 8'd200) begin n_fail++; $display("FAIL subzero_mag got %0d want 200", mag_o); end
    if (carry_o !== 1'b0)   begin n_fail++; $display("FAIL subzero_carry got %b want 0", carry_o); end
  endtask

  task automatic test_equal_zero();
    int e;
    do_op(1'b0, 8'd55, 1'b0, 8'd55, 1'b1, e);
    n_checks += 4;
    if (e != 3)          begin n_fail++; $display("FAIL eqz_latency got %0d want 3", e); end
    if (mag_o  !== 8'd0) begin n_fail++; $display("FAIL eqz_mag got %0d want 0", mag_o); end
    if (zero_o !== 1'b1) begin n_fail++; $display("FAIL eqz_zero got %b want 1", zero_o); end
    if (sign_o !== 1'b0) begin n_fail++; $display("FAIL eqz_sign got %b want 0", sign_o); end
    do_op(1'b1, 8'd55, 1'b1, 8'd55, 1'b1, e);
    n_checks += 2;
    if (zero_o !== 1'b1) begin n_fail++; $display("FAIL eqzneg_zero got %b want 1", zero_o); end
    if (sign_o !== 1'b0) begin n_fail++; $display("FAIL eqzneg_sign got %b want 0", sign_o); end
  endtask

  task automatic test_norm();
    int e;
    do_op(1'b0, 8'd3, 1'b0, 8'd1, 1'b0, e);
    n_checks += 3;
    if (e != (NORM ? 8 : 3)) begin n_fail++; $display("FAIL norm_latency got %0d want %0d", e, NORM ? 8 : 3); end
    if (mag_o !== (NORM ? 8'd128 : 8'd4)) begin
      n_fail++; $display("FAIL norm_mag got %0d want %0d", mag_o, NORM ? 128 : 4);
    end
    if (shift_o !== (NORM ? 3'd5 : 3'd0)) begin
      n_fail++; $display("FAIL norm_shift got %0d want %0d", shift_o, NORM ? 5 : 0);
    end
  endtask

  task automatic test_reset_in_fix();
    int dones;
    @(negedge clk);
    sign_a_i = 1'b0; mag_a_i = 8'd200; sign_b_i = 1'b0; mag_b_i = 8'd100; op_sub_i = 1'b0;
    start_i = 1'b1;
    @(posedge clk); #1 start_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    n_checks += 4;
    if (ready_o !== 1'b1) begin n_fail++; $display("FAIL rstfix_ready got %b want 1", ready_o); end
    if (mag_o   !== 8'd0) begin n_fail++; $display("FAIL rstfix_mag got %0d want 0", mag_o); end
    if (carry_o !== 1'b0) begin n_fail++; $display("FAIL rstfix_carry got %b want 0", carry_o); end
    if (shift_o !== 3'd0) begin n_fail++; $display("FAIL rstfix_shift got %0d want 0", shift_o); end
    @(negedge clk) rst = 1'b0;
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done_o === 1'b1) dones++;
    end
    n_checks += 1;
    if (dones != 0) begin n_fail++; $display("FAIL rstfix_nodone got %0d want 0", dones); end
  endtask

  task automatic test_ignored_start();
    int dones;
    logic [N-1:0] got;
    @(negedge clk);
    sign_a_i = 1'b0; mag_a_i = 8'd100; sign_b_i = 1'b0; mag_b_i = 8'd30; op_sub_i = 1'b1;
    start_i = 1'b1;
    @(posedge clk); #1;
    mag_a_i = 8'd200; mag_b_i = 8'd100; op_sub_i = 1'b0;
    n_checks += 1;
    if (ready_o !== 1'b0) begin n_fail++; $display("FAIL busy_ready got %b want 0", ready_o); end
    @(posedge clk); #1 start_i = 1'b0;
    dones = 0;
    got = '0;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      if (done_o === 1'b1) begin dones++; got = mag_o; end
    end
    n_checks += 2;
    if (dones != 1) begin n_fail++; $display("FAIL ignored_done_count got %0d want 1", dones); end
    if (got !== (NORM ? 8'd140 : 8'd70)) begin
      n_fail++; $display("FAIL ignored_result got %0d want %0d", got, NORM ? 140 : 70);
    end
  endtask

  task automatic test_back_to_back();
    int e;
    do_op(1'b0, 8'd200, 1'b0, 8'd100, 1'b0, e);
    n_checks += 1;
    if (ready_o !== 1'b1) begin n_fail++; $display("FAIL b2b_ready got %b want 1", ready_o); end
    do_op(1'b0, 8'd128, 1'b0, 8'd1, 1'b0, e);
    n_checks += 3;
    if (e != 3)            begin n_fail++; $display("FAIL b2b_latency got %0d want 3", e); end
    if (mag_o   !== 8'd129) begin n_fail++; $display("FAIL b2b_mag got %0d want 129", mag_o); end
    if (carry_o !== 1'b0)   begin n_fail++; $display("FAIL b2b_carry got %b want 0", carry_o); end
  endtask

  initial begin
    test_reset();
    test_add_overflow();
    test_subtract();
    test_equal_zero();
    test_norm();
    test_reset_in_fix();
    test_ignored_start();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
